cla_add_sched: RTL
==================

CLA_ADD_SCHED -- requirements
Module: cla_add_sched

Interface
REQ-001 Parameters: none; operand width fixed at 16 bits, datapath nibble width fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset.
REQ-004 req0_valid  input  1  requester 0 has an add pending.
REQ-005 req0_a, req0_b  input  16 each  requester 0 operands; held stable while req0_valid=1 and not accepted.
REQ-006 req0_ready  output  1  requester 0 accepted on an edge where req0_valid=1 and req0_ready=1.
REQ-007 req1_valid, req1_a, req1_b, req1_ready  as REQ-004..006 for requester 1.
REQ-008 resp_valid  output  1  result available.
REQ-009 resp_ready  input  1  consumer takes result on an edge where resp_valid=1 and resp_ready=1.
REQ-010 resp_id  output  1  index of the requester that owns the result.
REQ-011 resp_sum  output  17  {carry_out, sum[15:0]}.
REQ-012 busy  output  1  high in ADD or DONE.

Function
REQ-013 The block shall time-share one 4-bit carry-lookahead stage (g=a&b, p=a|b, c[i+1]=g[i]|p[i]&c[i], sum=a^b^c) over 4 nibbles, LSB nibble first.
REQ-014 States shall be IDLE, ADD, DONE.
REQ-015 IDLE: req_ready shall be high only for the granted requester, combinationally from req*_valid and the priority pointer; the other ready shall be low.
REQ-016 Grant: only one valid -> that one; both valid -> the requester not served last (round-robin); neither -> no grant, both ready low.
REQ-017 Priority pointer last_id shall reset to 1 so requester 0 wins the first tie; it shall update to the accepted id on every acceptance.
REQ-018 Acceptance edge: latch operands and id, clear carry register to 0, clear nibble counter to 0, go to ADD.
REQ-019 ADD: each edge writes sum nibble[cnt] and carry register from the CLA stage using the carry register as carry-in; cnt increments; after the edge with cnt=3 go to DONE.
REQ-020 Latency: resp_valid shall go high exactly 4 edges after the accepting edge; ready shall be low for both requesters in ADD and DONE.
REQ-021 DONE: resp_valid=1; resp_id, resp_sum stable; hold indefinitely while resp_ready=0.
REQ-022 DONE with resp_ready=1: go to IDLE; resp_valid low next cycle; a new request is accepted no earlier than the edge after returning to IDLE (no bypass).
REQ-023 resp_sum[16] shall equal the final carry out; arithmetic is unsigned modulo 2^17, no overflow flag.
REQ-024 resp_valid=0 implies resp_sum and resp_id hold last value (don't-care to consumers).
REQ-025 req*_valid deasserting in IDLE before acceptance shall have no side effect.

Reset
REQ-026 rst_n=0 at an edge shall force IDLE, cnt=0, carry=0, last_id=1, resp_valid=0, resp_id=0, resp_sum=0, busy=0, regardless of state.
REQ-027 Reset mid-ADD or in DONE shall discard the operation; no response shall be produced for it.
REQ-028 While rst_n=0, req0_ready and req1_ready shall be 0.

Verification
REQ-029 r0: a=0xFFFF, b=0x0001, resp_ready=1 -> resp_valid 4 edges after accept, resp_sum=0x10000, resp_id=0.
REQ-030 Both valid on first cycle after reset (r0: 0x1234+0x1111, r1: 0x8000+0x8000) -> r0 served first (0x02345), then r1 (0x10000, id=1).
REQ-031 r1 continuously valid, r0 valid once -> grants alternate; r1 never starved more than one operation.
REQ-032 resp_ready=0 for 10 cycles in DONE -> resp_valid, resp_sum, resp_id stable; both ready low; accept resumes after handshake.
REQ-033 rst_n=0 at cnt=2 -> next cycle IDLE, all outputs zero, no response for aborted op; next request correct.
REQ-034 Random 16-bit operands, random valid/resp_ready, 10k ops -> every resp_sum equals a+b of its accepted request, in acceptance order.

Source files
------------

// File: rtl/cla_add_sched.sv
// Two-requester adder that time-shares one 4-bit carry-lookahead stage over
// four nibbles, with round-robin arbitration and a valid/ready response port.
module cla_add_sched (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic [15:0] req0_a,
  input  logic [15:0] req0_b,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [15:0] req1_a,
  input  logic [15:0] req1_b,
  output logic        req1_ready,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [16:0] resp_sum,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ADD, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] op_a, op_b;
  logic [11:0] work;
  logic [1:0]  cnt;
  logic        op_id, carry, last_id;
  logic        grant0, grant1, accept;
  logic [3:0]  nib_s;
  logic        nib_c;

  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic ci);
    logic [3:0] g, p;
    logic [4:0] c;
    g    = a & b;
    p    = a | b;
    c[0] = ci;
    for (int i = 0; i < 4; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return {c[4], a ^ b ^ c[3:0]};
  endfunction

  // Operands shift right one nibble per ADD cycle, so the stage always sees bits [3:0].
  assign {nib_c, nib_s} = cla4(op_a[3:0], op_b[3:0], carry);

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves a latch.
    state_nx = state;
    grant0   = req0_valid && (!req1_valid || last_id);
    grant1   = req1_valid && (!req0_valid || !last_id);
    accept   = (state == IDLE) && (grant0 || grant1);
    case (state)
      IDLE:    if (grant0 || grant1) state_nx = ADD;
      ADD:     if (cnt == 2'd3) state_nx = DONE;
      DONE:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign req0_ready = rst_n && (state == IDLE) && grant0;
  assign req1_ready = rst_n && (state == IDLE) && grant1;
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  // NOTE: sequential state uses non-blocking assignments only; control and
  // visible outputs reset, operand/partial-sum registers do not need to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= 2'd0;
      carry    <= 1'b0;
      last_id  <= 1'b1;
      op_id    <= 1'b0;
      resp_id  <= 1'b0;
      resp_sum <= 17'd0;
    end else begin
      state <= state_nx;
      if (accept) begin
        op_id   <= grant1;
        last_id <= grant1;
        carry   <= 1'b0;
        cnt     <= 2'd0;
      end else if (state == ADD) begin
        carry <= nib_c;
        cnt   <= cnt + 2'd1;
        if (cnt == 2'd3) begin
          resp_sum <= {nib_c, nib_s, work};
          resp_id  <= op_id;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_a <= grant1 ? req1_a : req0_a;
      op_b <= grant1 ? req1_b : req0_b;
    end else if (state == ADD) begin
      op_a <= {4'd0, op_a[15:4]};
      op_b <= {4'd0, op_b[15:4]};
      work <= {nib_s, work[11:4]};
    end
  end

endmodule
